sm_step_gen: RTL and testbench

//  Parametrised stepper-motor step/direction generator; replaces the fixed single-zone pulse counter.

---
 rtl/sm_step_gen.sv | 218 +++++++++++++++++++++
 tb/tb_sm_step_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sm_step_gen.sv
// Stepper-motor step/direction generator: picks a step count from three |dx| zones and
// emits that many STEP_DIV-timed pulses after a DIR_SETUP hold, with busy/done/abort/drop status.
module sm_step_gen #(
  parameter int WIDTH_IN  = 12,
  parameter int WIDTH_CNT = 17,
  parameter int DX_NEAR   = 10,
  parameter int DX_FAR    = 100,
  parameter int N_FAR     = 800,
  parameter int N_MID     = 39600,
  parameter int N_NEAR    = 80000,
  parameter int STEP_DIV  = 25,
  parameter int DIR_SETUP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_dx_valid,
  input  logic [WIDTH_IN-1:0] i_dx,
  output logic                o_drv_step,
  output logic                o_drv_dir,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted,
  output logic                o_cmd_drop
);

  localparam int TMAX = (STEP_DIV > DIR_SETUP) ? STEP_DIV : DIR_SETUP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [WIDTH_IN-1:0]  LP_DX_NEAR    = WIDTH_IN'(DX_NEAR);
  localparam logic [WIDTH_IN-1:0]  LP_DX_FAR     = WIDTH_IN'(DX_FAR);
  localparam logic [WIDTH_IN-1:0]  LP_DX_ONE     = WIDTH_IN'(1);
  localparam logic [WIDTH_CNT-1:0] LP_N_FAR      = WIDTH_CNT'(N_FAR);
  localparam logic [WIDTH_CNT-1:0] LP_N_MID      = WIDTH_CNT'(N_MID);
  localparam logic [WIDTH_CNT-1:0] LP_N_NEAR     = WIDTH_CNT'(N_NEAR);
  localparam logic [WIDTH_CNT-1:0] LP_CNT_ONE    = WIDTH_CNT'(1);
  localparam logic [WIDTH_CNT-1:0] LP_CNT_ZERO   = WIDTH_CNT'(0);
  localparam logic [TW-1:0]        LP_DIV_LAST   = TW'(STEP_DIV - 1);
  localparam logic [TW-1:0]        LP_SETUP_LAST = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0]        LP_TICK_ONE   = TW'(1);
  localparam logic [TW-1:0]        LP_TICK_ZERO  = TW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_step, r_dir, r_busy, r_done, r_abort, r_drop;
  logic                 w_step_nxt, w_dir_nxt, w_busy_nxt, w_done_nxt, w_abort_nxt, w_drop_nxt;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [WIDTH_CNT-1:0] r_left, w_left_nxt;

  logic [WIDTH_IN-1:0]  w_abs_dx;
  logic [WIDTH_CNT-1:0] w_zone_n;
  logic                 w_dx_nz;
  logic                 w_accept;
  logic                 w_setup_end;
  logic                 w_half_end;
  logic                 w_last_step;

  // Most negative dx wraps to 2^(WIDTH_IN-1), which is still correct read as unsigned.
  assign w_abs_dx    = i_dx[WIDTH_IN-1] ? (~i_dx + LP_DX_ONE) : i_dx;
  assign w_zone_n    = (w_abs_dx >= LP_DX_FAR)  ? LP_N_FAR :
                       (w_abs_dx >= LP_DX_NEAR) ? LP_N_MID : LP_N_NEAR;
  assign w_dx_nz     = |i_dx;
  assign w_accept    = i_dx_valid & i_enable;
  assign w_setup_end = (r_tick == LP_SETUP_LAST);
  assign w_half_end  = (r_tick == LP_DIV_LAST);
  assign w_last_step = ~r_step & w_half_end & (r_left == LP_CNT_ONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_dx_nz) w_state_nxt = ST_SETUP;
        else                     w_state_nxt = ST_IDLE;
      end
      ST_SETUP: begin
        if (!i_enable)        w_state_nxt = ST_IDLE;
        else if (w_setup_end) w_state_nxt = ST_RUN;
        else                  w_state_nxt = ST_SETUP;
      end
      ST_RUN: begin
        if (!i_enable)        w_state_nxt = ST_IDLE;
        else if (w_last_step) w_state_nxt = ST_DONE;
        else                  w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and move counters
  always_comb begin
    w_step_nxt  = r_step;
    w_dir_nxt   = r_dir;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    w_drop_nxt  = 1'b0;
    w_tick_nxt  = r_tick;
    w_left_nxt  = r_left;
    case (r_state)
      ST_IDLE: begin
        w_step_nxt = 1'b0;
        w_tick_nxt = LP_TICK_ZERO;
        if (w_accept && w_dx_nz) begin
          w_left_nxt = w_zone_n;
          w_dir_nxt  = ~i_dx[WIDTH_IN-1];
          w_busy_nxt = 1'b1;
        end else if (w_accept) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        w_drop_nxt = i_dx_valid;
        if (!i_enable) begin
          w_step_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_abort_nxt = 1'b1;
          w_tick_nxt  = LP_TICK_ZERO;
          w_left_nxt  = LP_CNT_ZERO;
        end else if (w_setup_end) begin
          w_step_nxt = 1'b1;
          w_tick_nxt = LP_TICK_ZERO;
        end else begin
          w_tick_nxt = r_tick + LP_TICK_ONE;
        end
      end
      ST_RUN: begin
        w_drop_nxt = i_dx_valid;
        if (!i_enable) begin
          // A truncated high half is not counted: r_left only moves at the end of a low half.
          w_step_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_abort_nxt = 1'b1;
          w_tick_nxt  = LP_TICK_ZERO;
          w_left_nxt  = LP_CNT_ZERO;
        end else if (w_half_end && r_step) begin
          w_step_nxt = 1'b0;
          w_tick_nxt = LP_TICK_ZERO;
        end else if (w_half_end) begin
          w_tick_nxt = LP_TICK_ZERO;
          w_left_nxt = r_left - LP_CNT_ONE;
          if (w_last_step) begin
            w_step_nxt = 1'b0;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_step_nxt = 1'b1;
          end
        end else begin
          w_tick_nxt = r_tick + LP_TICK_ONE;
        end
      end
      ST_DONE: begin
        w_drop_nxt = i_dx_valid;
        w_step_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_tick_nxt = LP_TICK_ZERO;
      end
      default: begin
        w_step_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_tick_nxt = LP_TICK_ZERO;
        w_left_nxt = LP_CNT_ZERO;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_drop  <= 1'b0;
      r_tick  <= LP_TICK_ZERO;
      r_left  <= LP_CNT_ZERO;
    end else begin
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      r_drop  <= w_drop_nxt;
      r_tick  <= w_tick_nxt;
      r_left  <= w_left_nxt;
    end
  end

  assign o_drv_step = r_step;
  assign o_drv_dir  = r_dir;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_aborted  = r_abort;
  assign o_cmd_drop = r_drop;

endmodule

// File: tb/tb_sm_step_gen.sv
// Self-checking bench for sm_step_gen with small step counts and short timing.
module tb_sm_step_gen;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_enable = 1'b0;
  logic              i_dx_valid = 1'b0;
  logic signed [11:0] i_dx = 12'sd0;
  logic              o_drv_step, o_drv_dir, o_busy, o_done, o_aborted, o_cmd_drop;

  int checks = 0;
  int failures = 0;

  sm_step_gen #(
    .WIDTH_IN(12), .WIDTH_CNT(17), .DX_NEAR(10), .DX_FAR(100),
    .N_FAR(8), .N_MID(4), .N_NEAR(2), .STEP_DIV(3), .DIR_SETUP(2)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_dx_valid(i_dx_valid), .i_dx(i_dx),
    .o_drv_step(o_drv_step), .o_drv_dir(o_drv_dir), .o_busy(o_busy), .o_done(o_done),
    .o_aborted(o_aborted), .o_cmd_drop(o_cmd_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [11:0] dx;
    logic               en;
    int                 n;
    logic               dir;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One strobe, then watch a fixed window; inj_c > 0 injects a second strobe after sample inj_c.
  task automatic run_move(input logic signed [11:0] dxv, input logic en, input int n_exp,
                          input logic dir_exp, input int inj_c, input string tag);
    int done_exp, done_c, n_done, rises, first_rise, last_rise, width_err, busy_err;
    int n_drop, drop_c, n_abort, drop_exp;
    logic prev, busy_exp;
    done_exp = !en ? -1 : (n_exp > 0 ? 3 + 6 * n_exp : 1);
    drop_exp = (inj_c > 0) ? inj_c + 1 : -1;
    done_c = -1; n_done = 0; rises = 0; first_rise = -1; last_rise = -100;
    width_err = 0; busy_err = 0; n_drop = 0; drop_c = -1; n_abort = 0; prev = 1'b0;
    @(negedge clk);
    i_dx = dxv; i_enable = en; i_dx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) begin i_dx_valid = 1'b0; i_enable = 1'b1; end
      if (o_drv_step && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        else if (c - last_rise != 6) width_err++;
        last_rise = c;
      end
      if (!o_drv_step && prev && (c - last_rise != 3)) width_err++;
      busy_exp = (n_exp > 0) && en && (c < done_exp);
      if (o_busy != busy_exp) busy_err++;
      if (o_done) begin n_done++; done_c = c; end
      if (o_cmd_drop) begin n_drop++; drop_c = c; end
      if (o_aborted) n_abort++;
      if (c == inj_c) begin i_dx = 12'sd5; i_dx_valid = 1'b1; end
      else if (c > 1) i_dx_valid = 1'b0;
      prev = o_drv_step;
    end
    chk($sformatf("%s pulses", tag), rises, n_exp);
    chk($sformatf("%s dir", tag), int'(o_drv_dir), int'(dir_exp));
    chk($sformatf("%s done_cycle", tag), done_c, done_exp);
    chk($sformatf("%s done_count", tag), n_done, (done_exp > 0) ? 1 : 0);
    chk($sformatf("%s first_rise", tag), first_rise, (n_exp > 0) ? 3 : -1);
    chk($sformatf("%s width_err", tag), width_err, 0);
    chk($sformatf("%s busy_err", tag), busy_err, 0);
    chk($sformatf("%s abort_count", tag), n_abort, 0);
    chk($sformatf("%s drop_cycle", tag), drop_c, drop_exp);
    chk($sformatf("%s drop_count", tag), n_drop, (inj_c > 0) ? 1 : 0);
  endtask

  initial begin
    int rises, n_done, n_abort;
    logic prev;
    vecs[0]  = '{12'sd150,   1'b1, 8, 1'b1};
    vecs[1]  = '{-12'sd50,   1'b1, 4, 1'b0};
    vecs[2]  = '{-12'sd5,    1'b1, 2, 1'b0};
    vecs[3]  = '{12'sh800,   1'b1, 8, 1'b0};
    vecs[4]  = '{12'sd0,     1'b1, 0, 1'b0};
    vecs[5]  = '{12'sd99,    1'b1, 4, 1'b1};
    vecs[6]  = '{12'sd100,   1'b1, 8, 1'b1};
    vecs[7]  = '{12'sd10,    1'b1, 4, 1'b1};
    vecs[8]  = '{12'sd9,     1'b1, 2, 1'b1};
    vecs[9]  = '{-12'sd1,    1'b1, 2, 1'b0};
    vecs[10] = '{12'sd150,   1'b0, 0, 1'b0};
    vecs[11] = '{12'sd2047,  1'b1, 8, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({o_drv_step, o_drv_dir, o_busy, o_done, o_aborted, o_cmd_drop}), 0);
    rst = 1'b0;
    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outputs", int'({o_drv_step, o_drv_dir, o_busy, o_done, o_aborted, o_cmd_drop}), 0);

    foreach (vecs[i]) run_move(vecs[i].dx, vecs[i].en, vecs[i].n, vecs[i].dir, 0, $sformatf("v%0d", i));

    // Abort during the third high half, then a fresh command is accepted normally
    rises = 0; n_done = 0; n_abort = 0; prev = 1'b0;
    @(negedge clk);
    i_dx = 12'sd150; i_dx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      i_dx_valid = 1'b0;
      if (o_drv_step && !prev) rises++;
      if (o_done) n_done++;
      if (o_aborted) n_abort++;
      if (c == 17) begin
        chk("abort_step_low", int'(o_drv_step), 0);
        chk("abort_pulse", int'(o_aborted), 1);
        chk("abort_busy_low", int'(o_busy), 0);
      end
      if (c == 18) chk("abort_one_cycle", int'(o_aborted), 0);
      if (c == 16) i_enable = 1'b0;
      prev = o_drv_step;
    end
    chk("abort_pulses", rises, 3);
    chk("abort_no_done", n_done, 0);
    chk("abort_count", n_abort, 1);
    i_enable = 1'b1;
    run_move(12'sd20, 1'b1, 4, 1'b1, 0, "after_abort");

    // Second strobe during RUN, and one landing on the DONE cycle
    run_move(12'sd150, 1'b1, 8, 1'b1, 10, "drop_run");
    run_move(-12'sd150, 1'b1, 8, 1'b0, 51, "drop_done");

    // Asynchronous reset while a step pulse is high
    @(negedge clk);
    i_dx = 12'sd150; i_dx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_dx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_step_high", int'(o_drv_step), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({o_drv_step, o_drv_dir, o_busy, o_done, o_aborted, o_cmd_drop}), 0);
    @(negedge clk);
    rst = 1'b0;
    run_move(12'sd30, 1'b1, 4, 1'b1, 0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
